debounce_bank: RTL and testbench

//  N-channel switch/button conditioner for front-panel inputs (run/halt, single-step,

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/debounce_bank.sv | 46 ++++
 tb/tb_debounce_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Brief    : Shared timing defaults and counter-width helper for debounce_bank.
//  Revision : 1.0
// ============================================================================
package debounce_pkg;

    // Defaults for a 50 MHz board: 100 ms debounce, 1 s repeat delay, 200 ms period.
    localparam int unsigned c_debounce_time_default = 5_000_000;
    localparam int unsigned c_repeat_delay_default  = 50_000_000;
    localparam int unsigned c_repeat_period_default = 10_000_000;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Brief    : One switch channel: synchroniser, stability-count debounce,
//             press/release strobes and optional auto-repeat.
//  Revision : 1.0
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TIME = c_debounce_time_default,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic        RESET_LEVEL   = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = c_repeat_delay_default,
    parameter int unsigned REPEAT_PERIOD = c_repeat_period_default
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_debounced,
    output logic press,
    output logic sw_release
);

    localparam int c_cnt_w = cnt_width(DEBOUNCE_TIME);
    localparam int c_rpt_w = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD);
    localparam logic [c_cnt_w-1:0] c_db_last     = c_cnt_w'(DEBOUNCE_TIME - 1);
    localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_rpt_w-1:0]     r_rpt;
    logic                   r_first;
    logic                   r_state;
    logic                   r_press;
    logic                   r_release;

    logic                   w_s;
    logic                   w_accept;
    logic                   w_rpt_fire;
    logic [c_rpt_w-1:0]     w_rpt_limit;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_accept    = (w_s != r_state) && (r_cnt == c_db_last);
    assign w_rpt_limit = r_first ? c_delay_last : c_period_last;
    // An accepted change always outranks a repeat tick falling on the same cycle.
    assign w_rpt_fire  = REPEAT_EN && r_state && !w_accept && (r_rpt == w_rpt_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= {SYNC_STAGES{RESET_LEVEL}};
            r_state   <= RESET_LEVEL;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_first   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], sw_in};
            r_press   <= 1'b0;
            r_release <= 1'b0;

            if (w_s == r_state) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_state   <= w_s;
                r_cnt     <= '0;
                r_press   <= w_s;
                r_release <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (!REPEAT_EN || !r_state || w_accept) begin
                r_rpt   <= '0;
                r_first <= 1'b1;
            end else if (w_rpt_fire) begin
                r_press <= 1'b1;
                r_rpt   <= '0;
                r_first <= 1'b0;
            end else begin
                r_rpt <= r_rpt + 1'b1;
            end
        end
    end

    assign sw_debounced = r_state;
    assign press        = r_press;
    assign sw_release   = r_release;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bank
//  Brief    : N independent front-panel switch conditioners. The release strobe
//             port is named sw_release because "release" is a reserved word.
//  Revision : 1.0
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned          CHANNELS      = 4,
    parameter int unsigned          DEBOUNCE_TIME = c_debounce_time_default,
    parameter int unsigned          SYNC_STAGES   = 2,
    parameter logic                 RESET_LEVEL   = 1'b0,
    parameter logic [CHANNELS-1:0]  REPEAT_MASK   = '0,
    parameter int unsigned          REPEAT_DELAY  = c_repeat_delay_default,
    parameter int unsigned          REPEAT_PERIOD = c_repeat_period_default
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sw_in,
    output logic [CHANNELS-1:0] sw_debounced,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] sw_release
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_TIME (DEBOUNCE_TIME),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_LEVEL),
            .REPEAT_EN     (REPEAT_MASK[i]),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .sw_in        (sw_in[i]),
            .sw_debounced (sw_debounced[i]),
            .press        (press[i]),
            .sw_release   (sw_release[i])
        );
    end : g_chan

endmodule : debounce_bank
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_bank
//  Brief    : Directed-vector bench for debounce_bank (2 channels, ch1 repeats).
//  Revision : 1.0
// ============================================================================
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw_in = 2'b11;
    logic [1:0] sw_debounced;
    logic [1:0] press;
    logic [1:0] sw_release;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS      (2),
        .DEBOUNCE_TIME (4),
        .SYNC_STAGES   (2),
        .RESET_LEVEL   (1'b0),
        .REPEAT_MASK   (2'b10),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .sw_debounced (sw_debounced),
        .press        (press),
        .sw_release   (sw_release)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector layout for every comparison: {deb[1:0], press[1:0], release[1:0]}.
    task automatic test_reset();
        logic [5:0] exp;
        rst   = 1'b1;
        sw_in = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = 6'b000000;
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
        rst   = 1'b0;
        sw_in = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = 6'b000000;
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL post_reset k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [5:0] exp;
        sw_in = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {1'b0, k >= 6, 1'b0, k == 6, 2'b00};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL step_rise k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
        sw_in = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 6};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL step_fall k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
    endtask

    // High for 3 samples, one low glitch, then steady high: accept only after 4 clean highs.
    task automatic test_bounce();
        logic [5:0] exp;
        for (int k = 1; k <= 12; k++) begin
            sw_in = (k == 4) ? 2'b00 : 2'b01;
            tick();
            exp = {1'b0, k >= 10, 1'b0, k == 10, 2'b00};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
        sw_in = 2'b00;
        for (int k = 1; k <= 7; k++) tick();
        exp = 6'b000000;
        n_vec++;
        if ({sw_debounced, press, sw_release} !== exp) begin
            n_err++;
            $display("FAIL bounce_settle got=%b exp=%b", {sw_debounced, press, sw_release}, exp);
        end
    endtask

    // Both held high: ch1 repeats at 6, 16, 19, 22; ch0 presses only at 6.
    task automatic test_repeat();
        logic [5:0] exp;
        sw_in = 2'b11;
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp = {k >= 6, k >= 6,
                   (k == 6) || (k == 16) || (k == 19) || (k == 22), k == 6,
                   2'b00};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL repeat k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
    endtask

    // Continues the repeat timeline: ch1 released so acceptance lands on the repeat due at 28.
    task automatic test_release_on_repeat();
        logic [5:0] exp;
        sw_in = 2'b01;
        for (int k = 23; k <= 36; k++) begin
            tick();
            exp = {k < 28, 1'b1, k == 25, 1'b0, k == 28, 1'b0};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL release_rpt k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
    endtask

    // Reset lands when ch0's count is at 3; the change must restart from scratch.
    task automatic test_reset_mid_count();
        logic [5:0] exp;
        sw_in = 2'b00;
        for (int k = 1; k <= 8; k++) tick();
        sw_in = 2'b01;
        for (int k = 1; k <= 13; k++) begin
            rst = (k == 6);
            tick();
            exp = {1'b0, k >= 12, 1'b0, k == 12, 2'b00};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL reset_mid k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp;
        sw_in = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k >= 6, k < 6, k == 6, 1'b0, 1'b0, k == 6};
            n_vec++;
            if ({sw_debounced, press, sw_release} !== exp) begin
                n_err++;
                $display("FAIL simul k=%0d got=%b exp=%b", k, {sw_debounced, press, sw_release}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_repeat();
        test_release_on_repeat();
        test_reset_mid_count();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_debounce_bank
`default_nettype wire
